inst_loader: RTL

Byte-serial program loader that writes 32-bit instruction words into the single-cycle CPU's instruction memory. It is the write side of that memory: the CPU fetches words by address, and this block assembles words from an 8-bit valid/ready byte stream and writes them to consecutive word addresses starting at 0. While loading, it holds the CPU in reset and releases it when the last word has been written.

---
 rtl/inst_loader.sv | 85 ++++++++
 1 files changed

// File: rtl/inst_loader.sv
// inst_loader: byte-serial loader assembling 32-bit words into instruction memory while holding the CPU in reset.
module inst_loader #(
  parameter int AW = 6,
  parameter int NW = 7
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          starta,
  input  logic [NW-1:0] lena,
  input  logic [7:0]    dina,
  input  logic          vala,
  output logic          rdya,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic [31:0]   douta,
  output logic          busya,
  output logic          donea,
  output logic          erra,
  output logic          cpu_rsta
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam logic [NW:0] MAXW = (NW+1)'(2**AW);
  state_t        state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic          len_ok;
  assign len_ok = (lena != '0) && ({1'b0, lena} <= MAXW);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (starta) begin
        if (len_ok) begin
          cnt_d   = lena;
          addr_d  = '0;
          bcnt_d  = '0;
          state_d = RECV;
        end else err_d = 1'b1;
      end
      RECV: if (vala) begin
        data_d  = {data_q[23:0], dina};
        bcnt_d  = bcnt_q + 2'd1;
        state_d = (bcnt_q == 2'd3) ? WRITE : RECV;
      end
      WRITE: begin
        cnt_d   = cnt_q - NW'(1);
        addr_d  = addr_q + AW'(1);
        state_d = (cnt_q == NW'(1)) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  assign rdya     = state_q == RECV;
  assign wea      = state_q == WRITE;
  assign busya    = (state_q == RECV) || (state_q == WRITE);
  assign donea    = state_q == DONE;
  assign erra     = err_q;
  assign addra    = addr_q;
  assign douta    = data_q;
  assign cpu_rsta = rsta & ~busya;
endmodule
